fifo_rd_streamer: RTL and testbench

//  Read-side controller for the dual-clock sample FIFO, running in the read clock domain.
//  - Issues FIFO read strobes and absorbs the FIFO's 1-cycle registered read latency.
//  - Presents samples to the FIR datapath as a valid/ready stream; sustains 1 sample/clk.
//  - Never strobes a read while the FIFO reports empty.

---
 rtl/fifo_rd_streamer_pkg.sv | 26 ++
 rtl/fifo_rd_streamer_if.sv | 30 +++
 rtl/fifo_rd_skid.sv | 50 +++++
 rtl/fifo_rd_streamer.sv | 81 ++++++++
 tb/tb_fifo_rd_streamer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// Shared definitions for the FIFO read-side streamer: FSM encoding, buffer sizing
// and the ceil-log2 helper.
package fifo_rd_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Occupancy counts 0..2, so it needs enough bits for three values.
    localparam int OCC_W = clogb2(3);

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// Signal bundle between the read-side streamer, the sample FIFO and the FIR input.
// Stream handshake: a sample transfers on a clock edge where o_valid & i_ready; once
// o_valid is raised, o_valid and o_data hold until that transfer happens.
interface fifo_rd_streamer_if
    import fifo_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             i_enable;
    logic             i_fifo_empty;
    logic             o_fifo_rden;
    logic [WIDTH-1:0] i_fifo_rdata;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_busy;
    logic             o_last;
    state_t           dbg_state;
    logic [OCC_W-1:0] dbg_occ;

    modport slave (
        input  i_enable, i_fifo_empty, i_fifo_rdata, i_ready,
        output o_fifo_rden, o_valid, o_data, o_busy, o_last, dbg_state, dbg_occ
    );

    modport master (
        output i_enable, i_fifo_empty, i_fifo_rdata, i_ready,
        input  o_fifo_rden, o_valid, o_data, o_busy, o_last, dbg_state, dbg_occ
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head is the registered output sample, tail holds the second
// entry; samples leave in arrival order.
module fifo_rd_skid
    import fifo_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] tail;
    logic             do_pop;

    assign do_pop = pop & (occ != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == '0) head <= push_data;
                    else           tail <= push_data;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - OCC_W'(1);
                end
                // Simultaneous push and pop: occupancy is unchanged, head advances.
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side FIFO controller: issues credit-limited read strobes, absorbs the 1-cycle
// read latency and streams samples out. FIFO_RD_LAST_EN adds the frame o_last flag.
module fifo_rd_streamer
    import fifo_rd_streamer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 64
) (
    input logic               i_clk,
    input logic               i_rstn,
    fifo_rd_streamer_if.slave bus
);
    state_t           state;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] credit;
    logic             pop;
    logic             rden;

    if (FRAME_LEN < 2) begin : g_frame_len_check
        $error("fifo_rd_streamer: FRAME_LEN must be >= 2");
    end

    assign pop    = bus.o_valid & bus.i_ready;
    assign credit = occ + OCC_W'(inflight);
    // A full credit window may still issue a read when a pop frees a slot this cycle.
    assign rden   = (state == ST_RUN) & ~bus.i_fifo_empty &
                    ((credit < OCC_W'(2)) | ((credit == OCC_W'(2)) & pop));

    assign bus.o_fifo_rden = rden;
    assign bus.o_valid     = (occ != '0);
    assign bus.o_busy      = (state != ST_IDLE) | inflight | (occ != '0);
    assign bus.dbg_state   = state;
    assign bus.dbg_occ     = occ;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            inflight <= rden;
            case (state)
                ST_IDLE: if (bus.i_enable) state <= ST_RUN;
                ST_RUN:  if (!bus.i_enable) state <= ST_STOP;
                ST_STOP: begin
                    if (bus.i_enable)  state <= ST_RUN;
                    else if (!inflight) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (i_clk),
        .rstn      (i_rstn),
        .push      (inflight),
        .push_data (bus.i_fifo_rdata),
        .pop       (pop),
        .occ       (occ),
        .head      (bus.o_data)
    );

`ifdef FIFO_RD_LAST_EN
    logic [15:0] cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt <= '0;
        end else if ((state == ST_IDLE) && bus.i_enable) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= (cnt == 16'(FRAME_LEN - 1)) ? 16'd0 : cnt + 16'd1;
        end
    end

    assign bus.o_last = bus.o_valid & (cnt == 16'(FRAME_LEN - 1));
`else
    assign bus.o_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a registered-read FIFO model and an
// in-order scoreboard; define FIFO_RD_LAST_EN to exercise o_last with FRAME_LEN=4.
module tb_fifo_rd_streamer;
  import fifo_rd_streamer_pkg::*;

  localparam int WIDTH = 16;
`ifdef FIFO_RD_LAST_EN
  localparam int FL      = 4;
  localparam bit LAST_ON = 1'b1;
`else
  localparam int FL      = 64;
  localparam bit LAST_ON = 1'b0;
`endif

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_streamer_if #(.WIDTH(WIDTH)) ifc ();

  fifo_rd_streamer #(.WIDTH(WIDTH), .FRAME_LEN(FL)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (ifc.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] push_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  int pop_total  = 0;
  int last_seen  = 0;
  int last_base  = 0;
  int seen_base  = 0;
  bit window     = 1'b0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    push_q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: writes land at the next edge, reads return data one cycle after rden.
  initial begin
    ifc.i_fifo_empty = 1'b1;
    ifc.i_fifo_rdata = '0;
  end

  always @(posedge clk) begin
    while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    if (ifc.o_fifo_rden && fifo_q.size() != 0) ifc.i_fifo_rdata <= fifo_q.pop_front();
    ifc.i_fifo_empty <= (fifo_q.size() == 0);
  end

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (ifc.o_fifo_rden) check("rden_while_empty", ifc.i_fifo_empty, 1'b0);
      if (ifc.dbg_occ > 2) check("occ_le_2", ifc.dbg_occ, 2);
      if (prev_stall) begin
        check("hold_valid", ifc.o_valid, 1'b1);
        check("hold_data", ifc.o_data, prev_data);
      end
      if (window || !LAST_ON)
        check("o_last", ifc.o_last,
              LAST_ON && ifc.o_valid && (((pop_total - last_base) % FL) == FL - 1));
      if (ifc.o_valid && ifc.i_ready) begin
        if (exp_q.size() == 0) check("extra_sample", ifc.o_data, 32'hdead);
        else check("stream_data", ifc.o_data, exp_q.pop_front());
        if (window && ifc.o_last) last_seen++;
        pop_total++;
      end
      prev_stall = ifc.o_valid & ~ifc.i_ready;
      prev_data  = ifc.o_data;
    end
  end

  initial begin
    int n;
    bit found;
    ifc.i_enable = 1'b0;
    ifc.i_ready  = 1'b0;

    // reset values
    #2;
    check("rst_rden", ifc.o_fifo_rden, 1'b0);
    check("rst_valid", ifc.o_valid, 1'b0);
    check("rst_data", ifc.o_data, 16'h0);
    check("rst_busy", ifc.o_busy, 1'b0);
    check("rst_last", ifc.o_last, 1'b0);
    check("rst_state", ifc.dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // streaming 0x0001..0x0010 with latency and throughput
    step();
    for (int i = 1; i <= 16; i++) load(16'(i));
    ifc.i_ready  = 1'b1;
    ifc.i_enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ifc.o_fifo_rden) found = 1'b1;
    end
    check("first_rden_seen", found, 1'b1);
    check("lat_valid_c0", ifc.o_valid, 1'b0);
    @(negedge clk);
    check("lat_valid_c1", ifc.o_valid, 1'b0);
    @(negedge clk);
    check("lat_valid_c2", ifc.o_valid, 1'b1);
    n = 1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ifc.o_valid) n++;
    end
    check("throughput_cycles", n, 16);
    @(negedge clk);
    check("drain_valid", ifc.o_valid, 1'b0);
    check("drain_rden", ifc.o_fifo_rden, 1'b0);
    check("stream_all_out", exp_q.size(), 0);

    // backpressure: ready toggles every cycle over 32 samples
    step();
    for (int i = 0; i < 32; i++) load(16'h0100 + 16'(i));
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      step();
      ifc.i_ready = ~ifc.i_ready;
    end
    check("bp_all_out", exp_q.size(), 0);
    step();
    ifc.i_ready = 1'b1;

    // stop: enable drops in the same cycle a read strobe is issued
    step();
    load(16'h0AAA);
    load(16'h0BBB);
    step();
    ifc.i_enable = 1'b0;
    @(negedge clk);
    check("stop_rden_issued", ifc.o_fifo_rden, 1'b1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.o_fifo_rden) n++;
    end
    check("stop_no_more_rden", n, 0);
    check("stop_state_idle", ifc.dbg_state, ST_IDLE);
    check("stop_busy", ifc.o_busy, 1'b0);
    check("stop_inflight_out", exp_q.size(), 1);
    check("stop_fifo_left", fifo_q.size(), 1);

    // empty gap: 3 samples now (0x0BBB already queued), 5 more ten cycles later
    step();
    load(16'h0C01);
    load(16'h0C02);
    ifc.i_enable = 1'b1;
    repeat (9) @(negedge clk);
    check("gap_valid", ifc.o_valid, 1'b0);
    check("gap_rden", ifc.o_fifo_rden, 1'b0);
    check("gap_drained", exp_q.size(), 0);
    step();
    for (int i = 1; i <= 5; i++) load(16'h0D00 + 16'(i));
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    check("gap_all_out", exp_q.size(), 0);

    // frame marker over 12 samples after a fresh IDLE -> RUN
    step();
    ifc.i_enable = 1'b0;
    repeat (5) step();
    check("last_pre_idle", ifc.dbg_state, ST_IDLE);
    last_base = pop_total;
    seen_base = last_seen;
    window    = 1'b1;
    for (int i = 0; i < 12; i++) load(16'h0E00 + 16'(i));
    ifc.i_enable = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    window = 1'b0;
    check("last_all_out", exp_q.size(), 0);
    check("last_count", last_seen - seen_base, LAST_ON ? 3 : 0);

    // asynchronous reset with the buffer full
    step();
    ifc.i_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load(16'h0F00 + 16'(i));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ifc.dbg_occ == 2) found = 1'b1;
    end
    check("occ2_reached", found, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", ifc.o_valid, 1'b0);
    check("arst_rden", ifc.o_fifo_rden, 1'b0);
    check("arst_data", ifc.o_data, 16'h0);
    check("arst_busy", ifc.o_busy, 1'b0);
    check("arst_last", ifc.o_last, 1'b0);
    check("arst_occ", ifc.dbg_occ, 0);
    check("arst_state", ifc.dbg_state, ST_IDLE);
    exp_q.delete();
    fifo_q.delete();
    push_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.o_valid) n++;
    end
    check("post_rst_valid", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
